// File: rtl/placar_contador_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : placar_contador_pkg                                    |
// | Description : Shared constants and FSM encoding for the scoreboard.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package placar_contador_pkg;

  localparam int MAX_PLACAR = 999;
  localparam int PLACAR_W   = 10;

  typedef enum logic [1:0] {
    JOGANDO  = 2'd0,
    ATUALIZA = 2'd1,
    FIM      = 2'd2
  } estado_t;

endpackage : placar_contador_pkg
`default_nettype wire

// File: rtl/placar_soma_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : placar_soma_sat                                        |
// | Description : Score + points adder, saturating at MAX_PLACAR.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module placar_soma_sat
  import placar_contador_pkg::*;
#(
  parameter int PONTOS_W = 4
) (
  input  logic [PLACAR_W-1:0] base,
  input  logic [PONTOS_W-1:0] pontos,
  output logic [PLACAR_W-1:0] soma
);

  localparam logic [PLACAR_W:0] C_MAX_EXT = (PLACAR_W + 1)'(MAX_PLACAR);

  // One extra bit so the carry out of the 10-bit score is never lost.
  logic [PLACAR_W:0] w_soma_ext;

  // Add at 11 bits, then clamp to the display maximum.
  always_comb begin
    w_soma_ext = {1'b0, base} + (PLACAR_W + 1)'(pontos);
    if (w_soma_ext > C_MAX_EXT) begin
      soma = PLACAR_W'(MAX_PLACAR);
    end else begin
      soma = w_soma_ext[PLACAR_W-1:0];
    end
  end

endmodule : placar_soma_sat
`default_nettype wire

// File: rtl/placar_contador.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : placar_contador                                        |
// | Description : Two-sided game scoreboard with valid/ready event input,|
// |               saturating scores and end-of-game detection.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module placar_contador
  import placar_contador_pkg::*;
#(
  parameter int ALVO     = 100,
  parameter int PONTOS_W = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                reiniciar,
  input  logic                evento_valid,
  input  logic                evento_oponente,
  input  logic [PONTOS_W-1:0] evento_pontos,
  output logic                evento_ready,
  output logic [PLACAR_W-1:0] placar,
  output logic [PLACAR_W-1:0] placarOponente,
  output logic                fim_jogo,
  output logic                vencedor
);

  localparam logic [PLACAR_W-1:0] C_ALVO = PLACAR_W'(ALVO);

  estado_t               r_estado;
  estado_t               w_estado_prox;
  logic [PLACAR_W-1:0]   r_placar;
  logic [PLACAR_W-1:0]   r_placar_op;
  logic                  r_fim;
  logic                  r_vencedor;
  logic                  r_lado;        // side credited by the event under check
  logic                  w_aceita;
  logic                  w_atingiu;
  logic [PLACAR_W-1:0]   w_base;
  logic [PLACAR_W-1:0]   w_soma;

  // Ready only while playing, and never during reset or a restart request.
  always_comb begin
    evento_ready = (r_estado == JOGANDO) && !reiniciar && !reset;
    w_aceita     = evento_valid && evento_ready;
    w_base       = evento_oponente ? r_placar_op : r_placar;
    w_atingiu    = (r_lado ? r_placar_op : r_placar) >= C_ALVO;
  end

  // Single shared adder; the operand is picked by the credited side.
  placar_soma_sat #(
    .PONTOS_W (PONTOS_W)
  ) u_soma (
    .base   (w_base),
    .pontos (evento_pontos),
    .soma   (w_soma)
  );

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_estado <= JOGANDO;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // Next-state logic: accept -> one check cycle -> play again or game over.
  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      JOGANDO:  if (w_aceita) w_estado_prox = ATUALIZA;
      ATUALIZA: w_estado_prox = w_atingiu ? FIM : JOGANDO;
      FIM:      w_estado_prox = FIM;
      default:  w_estado_prox = JOGANDO;
    endcase
    if (reiniciar) begin
      w_estado_prox = JOGANDO;
    end
  end

  // Scores, credited side and game-over flags.
  always_ff @(posedge CLOCK_50) begin
    if (reset || reiniciar) begin
      r_placar    <= '0;
      r_placar_op <= '0;
      r_fim       <= 1'b0;
      r_vencedor  <= 1'b0;
      r_lado      <= 1'b0;
    end else begin
      if (w_aceita) begin
        r_lado <= evento_oponente;
        if (evento_oponente) begin
          r_placar_op <= w_soma;
        end else begin
          r_placar    <= w_soma;
        end
      end
      if ((r_estado == ATUALIZA) && w_atingiu) begin
        r_fim      <= 1'b1;
        r_vencedor <= r_lado;
      end
    end
  end

  assign placar         = r_placar;
  assign placarOponente = r_placar_op;
  assign fim_jogo       = r_fim;
  assign vencedor       = r_vencedor;

endmodule : placar_contador
`default_nettype wire
